// File: rtl/io_control_if.sv
// Button and datapath-command bundle between the drawing pad and io_control.
// Defining IO_ERASE_CELL_EN adds the btn_erase_cell input.
interface io_control_if #(
    parameter int GRID_COLS = 14,
    parameter int GRID_ROWS = 14
);
    logic btn_up;
    logic btn_down;
    logic btn_left;
    logic btn_right;
    logic btn_paint;
    logic btn_clear;
`ifdef IO_ERASE_CELL_EN
    logic btn_erase_cell;
`endif

    logic                           draw;
    logic                           erase;
    logic                           count_reset;
    logic [7:0]                     x_in;
    logic [7:0]                     y_in;
    logic                           plot;
    logic [2:0]                     colour;
    logic                           busy;
    logic [3:0]                     cur_col;
    logic [3:0]                     cur_row;
    logic [GRID_COLS*GRID_ROWS-1:0] grid;

    // The button source is the master; io_control is the slave.
    modport master (
`ifdef IO_ERASE_CELL_EN
        output btn_erase_cell,
`endif
        output btn_up, btn_down, btn_left, btn_right, btn_paint, btn_clear,
        input  draw, erase, count_reset, x_in, y_in, plot, colour, busy,
        input  cur_col, cur_row, grid
    );

    modport slave (
`ifdef IO_ERASE_CELL_EN
        input  btn_erase_cell,
`endif
        input  btn_up, btn_down, btn_left, btn_right, btn_paint, btn_clear,
        output draw, erase, count_reset, x_in, y_in, plot, colour, busy,
        output cur_col, cur_row, grid
    );
endinterface

// File: rtl/io_control.sv
// Drawing-pad control FSM: cursor tracking, cell bitmap and io_datapath commands.
// Defining IO_ERASE_CELL_EN adds a single-cell erase path driven by btn_erase_cell.
module io_control #(
    parameter int CELL_W    = 10,
    parameter int CELL_H    = 14,
    parameter int GRID_COLS = 14,
    parameter int GRID_ROWS = 14,
    parameter int ORIGIN_X  = 89,
    parameter int ORIGIN_Y  = 33
) (
    input  logic         clock,
    input  logic         reset,
    io_control_if.slave  bus
);
    localparam int NCELLS = GRID_COLS * GRID_ROWS;
    localparam int IDX_W  = $clog2(NCELLS);

    localparam logic [14:0] ERASE_LAST = 15'(GRID_COLS * CELL_W * GRID_ROWS * CELL_H - 1);
    localparam logic [14:0] DRAW_LAST  = 15'(CELL_W * CELL_H - 1);
    localparam logic [3:0]  LAST_COL   = 4'(GRID_COLS - 1);
    localparam logic [3:0]  LAST_ROW   = 4'(GRID_ROWS - 1);

    typedef enum logic [2:0] {
        S_LOAD_CLR,
        S_ERASE,
        S_IDLE,
        S_LOAD_DRW,
        S_DRAW
    } state_t;

    state_t            state, state_next;
    logic [14:0]       cnt, cnt_next;
    logic [3:0]        col, col_next;
    logic [3:0]        row, row_next;
    logic [7:0]        x_reg, y_reg;
    logic [NCELLS-1:0] grid_reg, grid_next;
    logic [IDX_W-1:0]  cell_idx;
    logic              draw_w, erase_w;
`ifdef IO_ERASE_CELL_EN
    logic              ink, ink_next;   // 1 = paint in white, 0 = paint in black
`endif

    assign cell_idx = IDX_W'(row) * IDX_W'(GRID_COLS) + IDX_W'(col);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path infers a latch.
        state_next = state;
        cnt_next   = cnt;
        col_next   = col;
        row_next   = row;
        grid_next  = grid_reg;
`ifdef IO_ERASE_CELL_EN
        ink_next   = ink;
`endif
        case (state)
            S_LOAD_CLR: begin
                cnt_next   = '0;
                state_next = S_ERASE;
            end
            S_LOAD_DRW: begin
                cnt_next   = '0;
                state_next = S_DRAW;
            end
            S_ERASE: begin
                if (cnt == ERASE_LAST) state_next = S_IDLE;
                else                   cnt_next   = cnt + 15'd1;
            end
            S_DRAW: begin
                if (cnt == DRAW_LAST) state_next = S_IDLE;
                else                  cnt_next   = cnt + 15'd1;
            end
            S_IDLE: begin
                if (bus.btn_clear) begin
                    grid_next  = '0;
                    state_next = S_LOAD_CLR;
                end
`ifdef IO_ERASE_CELL_EN
                else if (bus.btn_erase_cell) begin
                    grid_next[cell_idx] = 1'b0;
                    ink_next            = 1'b0;
                    state_next          = S_LOAD_DRW;
                end
`endif
                else if (bus.btn_paint) begin
                    grid_next[cell_idx] = 1'b1;
`ifdef IO_ERASE_CELL_EN
                    ink_next            = 1'b1;
`endif
                    state_next          = S_LOAD_DRW;
                end
                else begin
                    // Opposite buttons together leave the axis untouched; edges saturate.
                    if (bus.btn_right && !bus.btn_left && col != LAST_COL)
                        col_next = col + 4'd1;
                    else if (bus.btn_left && !bus.btn_right && col != 4'd0)
                        col_next = col - 4'd1;
                    if (bus.btn_down && !bus.btn_up && row != LAST_ROW)
                        row_next = row + 4'd1;
                    else if (bus.btn_up && !bus.btn_down && row != 4'd0)
                        row_next = row - 4'd1;
                end
            end
            default: state_next = S_LOAD_CLR;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: registers use non-blocking assignments so every flop updates from pre-edge values.
        if (reset) begin
            state    <= S_LOAD_CLR;
            cnt      <= '0;
            col      <= '0;
            row      <= '0;
            x_reg    <= 8'(ORIGIN_X);
            y_reg    <= 8'(ORIGIN_Y);
            // NOTE: grid is a flop bitmap rather than a RAM, so it can be cleared by reset.
            grid_reg <= '0;
`ifdef IO_ERASE_CELL_EN
            ink      <= 1'b1;
`endif
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            col      <= col_next;
            row      <= row_next;
            x_reg    <= 8'(ORIGIN_X) + 8'(CELL_W) * 8'(col_next);
            y_reg    <= 8'(ORIGIN_Y) + 8'(CELL_H) * 8'(row_next);
            grid_reg <= grid_next;
`ifdef IO_ERASE_CELL_EN
            ink      <= ink_next;
`endif
        end
    end

    assign draw_w  = (state == S_DRAW);
    assign erase_w = (state == S_ERASE);

    assign bus.draw        = draw_w;
    assign bus.erase       = erase_w;
    assign bus.plot        = draw_w | erase_w;
    assign bus.count_reset = !(state == S_LOAD_CLR || state == S_LOAD_DRW);
    assign bus.busy        = (state != S_IDLE);
`ifdef IO_ERASE_CELL_EN
    assign bus.colour      = (draw_w && ink) ? 3'b111 : 3'b000;
`else
    assign bus.colour      = draw_w ? 3'b111 : 3'b000;
`endif
    assign bus.x_in        = x_reg;
    assign bus.y_in        = y_reg;
    assign bus.cur_col     = col;
    assign bus.cur_row     = row;
    assign bus.grid        = grid_reg;
endmodule

// File: tb/tb_io_control.sv
// Self-checking bench for io_control: per-cycle compare against an operation-level model
// plus directed literal checks. Define IO_ERASE_CELL_EN to also exercise single-cell erase.
module tb_io_control;
    localparam int COLS      = 14;
    localparam int ROWS      = 14;
    localparam int NCELLS    = COLS * ROWS;
    localparam int ERASE_LEN = 27440;
    localparam int DRAW_LEN  = 140;

    localparam int B_RIGHT = 1;
    localparam int B_LEFT  = 2;
    localparam int B_DOWN  = 4;
    localparam int B_UP    = 8;
    localparam int B_PAINT = 16;
    localparam int B_CLEAR = 32;
    localparam int B_ECELL = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    io_control_if #(.GRID_COLS(COLS), .GRID_ROWS(ROWS)) bus ();

    io_control #(
        .CELL_W(10), .CELL_H(14), .GRID_COLS(COLS), .GRID_ROWS(ROWS),
        .ORIGIN_X(89), .ORIGIN_Y(33)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operation-level model: an operation is one load cycle followed by its active run.
    typedef enum {OP_NONE, OP_CLEAR, OP_PAINT, OP_ERASE_CELL} op_t;
    op_t               m_op    = OP_NONE;
    int                m_len   = 0;
    int                m_left  = 0;
    int                m_col   = 0;
    int                m_row   = 0;
    logic [NCELLS-1:0] m_grid  = '0;
    bit                m_valid = 1'b0;

    task automatic start_op(input op_t op);
        m_op   = op;
        m_len  = (op == OP_CLEAR) ? ERASE_LEN : DRAW_LEN;
        m_left = m_len + 1;
    endtask

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    task automatic model_step();
        if (reset === 1'b1) begin
            m_valid = 1'b1;
            m_col   = 0;
            m_row   = 0;
            m_grid  = '0;
            start_op(OP_CLEAR);
        end else if (m_valid) begin
            if (m_left > 0) m_left--;
            else if (bus.btn_clear) begin
                m_grid = '0;
                start_op(OP_CLEAR);
            end
`ifdef IO_ERASE_CELL_EN
            else if (bus.btn_erase_cell) begin
                m_grid[m_row*COLS + m_col] = 1'b0;
                start_op(OP_ERASE_CELL);
            end
`endif
            else if (bus.btn_paint) begin
                m_grid[m_row*COLS + m_col] = 1'b1;
                start_op(OP_PAINT);
            end else begin
                m_col = clamp(m_col + int'(bus.btn_right) - int'(bus.btn_left), COLS - 1);
                m_row = clamp(m_row + int'(bus.btn_down) - int'(bus.btn_up), ROWS - 1);
            end
        end
    endtask

    task automatic compare_cycle();
        logic       e_busy, e_load, e_active, e_draw, e_erase;
        logic [2:0] e_colour;
        e_busy   = (m_left != 0);
        e_load   = e_busy && (m_left == m_len + 1);
        e_active = e_busy && !e_load;
        e_erase  = e_active && (m_op == OP_CLEAR);
        e_draw   = e_active && (m_op != OP_CLEAR);
        e_colour = (e_active && m_op == OP_PAINT) ? 3'b111 : 3'b000;
        check("ctrl", 256'({bus.draw, bus.erase, bus.count_reset, bus.plot, bus.colour, bus.busy}),
              256'({e_draw, e_erase, !e_load, e_draw | e_erase, e_colour, e_busy}));
        check("cursor", 256'({bus.cur_col, bus.cur_row, bus.x_in, bus.y_in}),
              256'({4'(m_col), 4'(m_row), 8'(89 + m_col*10), 8'(33 + m_row*14)}));
        check("grid", 256'(bus.grid), 256'(m_grid));
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (m_valid) compare_cycle();
    end

    task automatic set_btns(input int b);
        bus.btn_right = (b & B_RIGHT) != 0;
        bus.btn_left  = (b & B_LEFT)  != 0;
        bus.btn_down  = (b & B_DOWN)  != 0;
        bus.btn_up    = (b & B_UP)    != 0;
        bus.btn_paint = (b & B_PAINT) != 0;
        bus.btn_clear = (b & B_CLEAR) != 0;
`ifdef IO_ERASE_CELL_EN
        bus.btn_erase_cell = (b & B_ECELL) != 0;
`endif
    endtask

    task automatic pulse(input int b);
        @(negedge clock);
        set_btns(b);
        @(negedge clock);
        set_btns(0);
    endtask

    // Counts output activity from the current cycle until busy falls, within a budget.
    task automatic run_op(output int n_load, output int n_draw, output int n_erase,
                          output int n_white, output int n_black);
        int n;
        n = 0; n_load = 0; n_draw = 0; n_erase = 0; n_white = 0; n_black = 0;
        while (bus.busy === 1'b1 && n < 30000) begin
            if (bus.count_reset === 1'b0) n_load++;
            if (bus.draw === 1'b1) n_draw++;
            if (bus.erase === 1'b1) n_erase++;
            if (bus.draw === 1'b1 && bus.colour === 3'b111) n_white++;
            if (bus.plot === 1'b1 && bus.draw === 1'b1 && bus.colour === 3'b000) n_black++;
            n++;
            @(negedge clock);
        end
        check("op_finishes", 256'(bus.busy), 256'(0));
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int                nl, nd, ne, nw, nb;
        logic [NCELLS-1:0] exp_grid;

        set_btns(0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Reset release: one load cycle then the full-pad erase.
        reset = 1'b0;
        run_op(nl, nd, ne, nw, nb);
        check("t1_load_cycles", 256'(nl), 256'(1));
        check("t1_erase_cycles", 256'(ne), 256'(27440));
        check("t1_draw_cycles", 256'(nd), 256'(0));
        check("t1_x_in", 256'(bus.x_in), 256'(89));
        check("t1_y_in", 256'(bus.y_in), 256'(33));
        check("t1_grid", 256'(bus.grid), 256'(0));

        // Move to (3,2) and paint.
        repeat (3) pulse(B_RIGHT);
        repeat (2) pulse(B_DOWN);
        check("t2_col", 256'(bus.cur_col), 256'(3));
        check("t2_row", 256'(bus.cur_row), 256'(2));
        pulse(B_PAINT);
        run_op(nl, nd, ne, nw, nb);
        check("t2_load_cycles", 256'(nl), 256'(1));
        check("t2_draw_cycles", 256'(nd), 256'(140));
        check("t2_white_cycles", 256'(nw), 256'(140));
        check("t2_erase_cycles", 256'(ne), 256'(0));
        check("t2_x_in", 256'(bus.x_in), 256'(119));
        check("t2_y_in", 256'(bus.y_in), 256'(61));
        exp_grid = '0;
        exp_grid[31] = 1'b1;
        check("t2_grid", 256'(bus.grid), 256'(exp_grid));

        // Saturation at the origin, cancelling opposite pairs, saturation at the far corner.
        repeat (2) pulse(B_LEFT | B_UP);
        pulse(B_LEFT);
        pulse(B_LEFT | B_UP);
        check("t3_origin", 256'({bus.cur_col, bus.cur_row}), 256'(8'h00));
        repeat (3) pulse(B_RIGHT | B_DOWN);
        pulse(B_LEFT | B_RIGHT | B_UP | B_DOWN);
        check("t3_cancel", 256'({bus.cur_col, bus.cur_row}), 256'(8'h33));
        repeat (10) pulse(B_RIGHT | B_DOWN);
        pulse(B_RIGHT);
        pulse(B_DOWN);
        check("t3_corner", 256'({bus.cur_col, bus.cur_row}), 256'(8'hdd));
        check("t3_x_in", 256'(bus.x_in), 256'(219));
        check("t3_y_in", 256'(bus.y_in), 256'(215));

        // Clear and paint together: clear wins.
        pulse(B_CLEAR | B_PAINT);
        run_op(nl, nd, ne, nw, nb);
        check("t4_erase_cycles", 256'(ne), 256'(27440));
        check("t4_draw_cycles", 256'(nd), 256'(0));
        check("t4_grid", 256'(bus.grid), 256'(0));

        // Paint at (13,13), pulse paint mid-draw, then reset at draw cycle 50.
        pulse(B_PAINT);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            if (k == 10) bus.btn_paint = 1'b1;
            if (k == 11) bus.btn_paint = 1'b0;
        end
        check("t5_draw_before_reset", 256'(bus.draw), 256'(1));
        exp_grid = '0;
        exp_grid[195] = 1'b1;
        check("t5_grid_before_reset", 256'(bus.grid), 256'(exp_grid));
        reset = 1'b1;
        @(negedge clock);
        check("t5_draw_after_reset", 256'(bus.draw), 256'(0));
        check("t5_count_reset", 256'(bus.count_reset), 256'(0));
        check("t5_grid_after_reset", 256'(bus.grid), 256'(0));
        reset = 1'b0;
        run_op(nl, nd, ne, nw, nb);
        check("t5_load_cycles", 256'(nl), 256'(1));
        check("t5_erase_cycles", 256'(ne), 256'(27440));
        check("t5_draw_cycles", 256'(nd), 256'(0));

`ifdef IO_ERASE_CELL_EN
        // Paint (2,2), then erase that single cell in black.
        repeat (2) pulse(B_RIGHT | B_DOWN);
        pulse(B_PAINT);
        run_op(nl, nd, ne, nw, nb);
        exp_grid = '0;
        exp_grid[30] = 1'b1;
        check("t6_grid_painted", 256'(bus.grid), 256'(exp_grid));
        pulse(B_ECELL);
        run_op(nl, nd, ne, nw, nb);
        check("t6_load_cycles", 256'(nl), 256'(1));
        check("t6_black_plot_cycles", 256'(nb), 256'(140));
        check("t6_white_cycles", 256'(nw), 256'(0));
        check("t6_grid_cleared", 256'(bus.grid), 256'(0));
`endif

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
